// File: rtl/pip_stage5_mem_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
interface pip_stage5_mem_if #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 8
);
    logic             dm_req;
    logic             dm_we;
    logic [ASIZE-1:0] dm_addr;
    logic [DSIZE-1:0] dm_wdata;
    logic             dm_ready;
    logic [DSIZE-1:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ready, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ready, dm_rdata
    );
endinterface

// File: rtl/pip_stage5_mem.sv
// MEM stage of the 5-stage pipeline: issues loads/stores on the data-memory
// port, stalls upstream while an access is outstanding, aborts with a sticky
// error after TIMEOUT unanswered access cycles, and holds the MEM/WB register.
module pip_stage5_mem #(
    parameter int DSIZE   = 16,
    parameter int ASIZE   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        w_addr_in,
    input  logic [DSIZE-1:0]  w_data_in,
    input  logic [DSIZE-1:0]  Rdata2_in,
    input  logic              memWrite_in,
    input  logic              memRead_in,
    input  logic              memToReg_in,
    input  logic              wen_in,
    pip_stage5_mem_if.master  dm,
    output logic              stall,
    output logic [3:0]        wb_addr,
    output logic [DSIZE-1:0]  wb_data,
    output logic              wb_wen,
    output logic              mem_err
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_cnt;
    logic             w_mem_op;
    logic             w_hit;
    logic             w_abort;
    logic             w_capture;
    logic             w_stall;
    logic             w_rd_sel;
    logic [DSIZE-1:0] w_rdata_eff;
    logic [DSIZE-1:0] w_wb_data;

    assign w_mem_op  = memRead_in | memWrite_in;
    assign w_hit     = (r_state == ACCESS) & dm.dm_ready;
    assign w_abort   = (r_state == ACCESS) & ~dm.dm_ready & (r_cnt == TIMEOUT_M1);

    // A write wins over a read when both bits are set, so the read data is dropped.
    assign w_rd_sel    = memToReg_in & ~memWrite_in;
    // On abort the access completes with the read data forced to zero.
    assign w_rdata_eff = w_hit ? dm.dm_rdata : '0;
    assign w_wb_data   = w_rd_sel ? w_rdata_eff : w_data_in;

    // Next-state, stall and MEM/WB capture decode.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_op) begin
                    w_stall     = 1'b1;
                    w_state_nxt = ACCESS;
                end else begin
                    w_capture   = 1'b1;
                end
            end
            ACCESS: begin
                if (w_hit || w_abort) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_stall     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reset must drop stall in the same instant even if a memory op is presented.
    assign stall = w_stall & rst;

    // Memory port decodes from state only; everything is quiet in IDLE.
    assign dm.dm_req   = (r_state == ACCESS);
    assign dm.dm_we    = (r_state == ACCESS) & memWrite_in;
    assign dm.dm_addr  = (r_state == ACCESS) ? w_data_in[ASIZE-1:0] : '0;
    assign dm.dm_wdata = (r_state == ACCESS) ? Rdata2_in : '0;

    // State register and saturating wait counter (cleared on entry to ACCESS).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE)
                r_cnt <= 8'd0;
            else if (!dm.dm_ready && r_cnt != 8'hFF)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    // MEM/WB register: capture on completion, otherwise insert a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_addr <= '0;
            wb_data <= '0;
            wb_wen  <= 1'b0;
        end else if (w_capture) begin
            wb_addr <= w_addr_in;
            wb_data <= w_wb_data;
            wb_wen  <= wen_in;
        end else begin
            wb_wen  <= 1'b0;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mem_err <= 1'b0;
        else if (w_abort)
            mem_err <= 1'b1;
    end

endmodule
